// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card power-up sequencer: CMD0 -> CMD8 -> (CMD55+ACMD41)* [-> CMD58] over a start/done
// handshake to the command engine. Define SD_INIT_CMD58_EN to read the OCR (CCS) on v2 cards.
module sd_init_sequencer #(
  parameter int NRESP_W          = 6,
  parameter int POWERUP_CYCLES   = 1024,
  parameter int CMD0_RETRIES     = 8,
  parameter int ACMD41_RETRIES   = 255,
  parameter int RETRY_GAP_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_start,
  output logic               cmd_start,
  output logic [5:0]         cmd_index,
  output logic [31:0]        cmd_arg,
  output logic [6:0]         cmd_crc,
  output logic [NRESP_W-1:0] cmd_nresp,
  input  logic               cmd_done,
  input  logic [39:0]        cmd_resp,
  output logic               busy,
  output logic               ready,
  output logic               error,
  output logic [2:0]         err_code,
  output logic               sd_v2,
  output logic               ccs
);

  localparam int DLY_MAX = (POWERUP_CYCLES > RETRY_GAP_CYCLES) ? POWERUP_CYCLES : RETRY_GAP_CYCLES;
  localparam int RTY_MAX = (CMD0_RETRIES > ACMD41_RETRIES) ? CMD0_RETRIES : ACMD41_RETRIES;
  localparam int CW      = $clog2(DLY_MAX + 1);
  localparam int AW      = $clog2(RTY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_ISSUE, S_WAIT, S_GAP, S_READY, S_ERROR
  } state_t;

  typedef enum logic [2:0] {C0, C8, C55, A41, C58} cmd_t;

  state_t        state, state_n;
  cmd_t          cur_cmd, cur_cmd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] attempt, attempt_n, attempt_inc;
  logic          sd_v2_n;
  logic [2:0]    err_code_n;
  logic [7:0]    r1;
  logic          unused_resp;

  assign r1          = cmd_resp[39:32];
  assign attempt_inc = attempt + AW'(1);
  assign unused_resp = ^cmd_resp[31:12];

  assign busy  = (state == S_PWRUP) || (state == S_ISSUE) || (state == S_WAIT) || (state == S_GAP);
  assign ready = (state == S_READY);
  assign error = (state == S_ERROR);

`ifdef SD_INIT_CMD58_EN
  logic ccs_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_cmd  <= C0;
      cnt      <= '0;
      attempt  <= '0;
      sd_v2    <= 1'b0;
      err_code <= 3'd0;
    end else begin
      state    <= state_n;
      cur_cmd  <= cur_cmd_n;
      cnt      <= cnt_n;
      attempt  <= attempt_n;
      sd_v2    <= sd_v2_n;
      err_code <= err_code_n;
    end
  end

`ifdef SD_INIT_CMD58_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ccs <= 1'b0;
    else        ccs <= ccs_n;
  end
`else
  assign ccs = 1'b0;
`endif

  // Command frame fields are loaded on entry to ISSUE and held through WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_index <= '0;
      cmd_arg   <= '0;
      cmd_crc   <= '0;
      cmd_nresp <= '0;
    end else if (state_n == S_ISSUE) begin
      case (cur_cmd_n)
        C0: begin
          cmd_index <= 6'd0;  cmd_arg <= 32'h0;     cmd_crc <= 7'h4A; cmd_nresp <= NRESP_W'(0);
        end
        C8: begin
          cmd_index <= 6'd8;  cmd_arg <= 32'h1AA;   cmd_crc <= 7'h43; cmd_nresp <= NRESP_W'(4);
        end
        C55: begin
          cmd_index <= 6'd55; cmd_arg <= 32'h0;     cmd_crc <= 7'h7F; cmd_nresp <= NRESP_W'(0);
        end
        A41: begin
          cmd_index <= 6'd41; cmd_arg <= sd_v2_n ? 32'h4000_0000 : 32'h0;
          cmd_crc   <= 7'h7F; cmd_nresp <= NRESP_W'(0);
        end
        default: begin
          cmd_index <= 6'd58; cmd_arg <= 32'h0;     cmd_crc <= 7'h7F; cmd_nresp <= NRESP_W'(4);
        end
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    cur_cmd_n  = cur_cmd;
    cnt_n      = cnt;
    attempt_n  = attempt;
    sd_v2_n    = sd_v2;
    err_code_n = err_code;
    cmd_start  = 1'b0;
`ifdef SD_INIT_CMD58_EN
    ccs_n      = ccs;
`endif
    case (state)
      S_IDLE, S_READY, S_ERROR: begin
        if (init_start) begin
          state_n    = S_PWRUP;
          cur_cmd_n  = C0;
          cnt_n      = '0;
          attempt_n  = '0;
          sd_v2_n    = 1'b0;
          err_code_n = 3'd0;
`ifdef SD_INIT_CMD58_EN
          ccs_n      = 1'b0;
`endif
        end
      end
      S_PWRUP: begin
        if (cnt == CW'(POWERUP_CYCLES - 1)) begin
          state_n   = S_ISSUE;
          cur_cmd_n = C0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_ISSUE: begin
        cmd_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (cmd_done) begin
          // Attempt count spans the whole CMD55/ACMD41 loop; it clears only on phase change.
          case (cur_cmd)
            C0: begin
              if (r1 == 8'h01) begin
                state_n = S_ISSUE; cur_cmd_n = C8; attempt_n = '0;
              end else begin
                attempt_n = attempt_inc;
                if (attempt_inc == AW'(CMD0_RETRIES)) begin
                  state_n = S_ERROR; err_code_n = 3'd1;
                end else begin
                  state_n = S_GAP; cnt_n = '0;
                end
              end
            end
            C8: begin
              if (r1 == 8'h01) begin
                if (cmd_resp[11:0] == 12'h1AA) begin
                  sd_v2_n = 1'b1; state_n = S_ISSUE; cur_cmd_n = C55; attempt_n = '0;
                end else begin
                  state_n = S_ERROR; err_code_n = 3'd3;
                end
              end else if (r1 == 8'h05) begin
                sd_v2_n = 1'b0; state_n = S_ISSUE; cur_cmd_n = C55; attempt_n = '0;
              end else begin
                state_n = S_ERROR; err_code_n = 3'd2;
              end
            end
            C55: begin
              if (r1 == 8'h00 || r1 == 8'h01) begin
                state_n = S_ISSUE; cur_cmd_n = A41;
              end else begin
                state_n = S_ERROR; err_code_n = 3'd4;
              end
            end
            A41: begin
              if (r1 == 8'h00) begin
`ifdef SD_INIT_CMD58_EN
                if (sd_v2) begin
                  state_n = S_ISSUE; cur_cmd_n = C58; attempt_n = '0;
                end else begin
                  state_n = S_READY;
                end
`else
                state_n = S_READY;
`endif
              end else if (r1 == 8'h01) begin
                attempt_n = attempt_inc;
                cur_cmd_n = C55;
                if (attempt_inc == AW'(ACMD41_RETRIES)) begin
                  state_n = S_ERROR; err_code_n = 3'd5;
                end else begin
                  state_n = S_GAP; cnt_n = '0;
                end
              end else begin
                state_n = S_ERROR; err_code_n = 3'd4;
              end
            end
            default: begin
`ifdef SD_INIT_CMD58_EN
              if (r1 == 8'h00) begin
                ccs_n = cmd_resp[30]; state_n = S_READY;
              end else begin
                state_n = S_ERROR; err_code_n = 3'd6;
              end
`else
              state_n = S_ERROR; err_code_n = 3'd4;
`endif
            end
          endcase
        end
      end
      S_GAP: begin
        if (cnt == CW'(RETRY_GAP_CYCLES - 1)) state_n = S_ISSUE;
        else                                  cnt_n   = cnt + CW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer: a scripted command-engine responder answers each command
// with hand-chosen R1/payload values and every scenario checks the resulting sequence and status.
module tb_sd_init_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_start = 1'b0;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic [5:0]  cmd_nresp;
  logic        cmd_done = 1'b0;
  logic [39:0] cmd_resp = '0;
  logic        busy, ready, error, sd_v2, ccs;
  logic [2:0]  err_code;

  int errors = 0;
  int checks = 0;

  // fields captured by serve() for the scenario tasks to compare
  logic [5:0]  s_idx;
  logic [31:0] s_arg;
  logic [6:0]  s_crc;
  logic [5:0]  s_nr;
  int          s_wait;
  bit          s_to;
  bit          s_single;

`ifdef SD_INIT_CMD58_EN
  localparam bit HAS58 = 1'b1;
`else
  localparam bit HAS58 = 1'b0;
`endif

  sd_init_sequencer dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .cmd_start(cmd_start), .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
    .cmd_nresp(cmd_nresp), .cmd_done(cmd_done), .cmd_resp(cmd_resp),
    .busy(busy), .ready(ready), .error(error), .err_code(err_code), .sd_v2(sd_v2), .ccs(ccs)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulses init_start and returns the cycle count until cmd_start; a second init_start
  // mid power-up must be ignored.
  task automatic start_init(output int n);
    init_start = 1'b1; tick(); init_start = 1'b0; n = 0;
    while (cmd_start !== 1'b1 && n < 3000) begin
      tick(); n++;
      if (n == 500) init_start = 1'b1;
      if (n == 501) init_start = 1'b0;
    end
  endtask

  // Waits (bounded) for the next cmd_start, captures the frame, answers with resp.
  task automatic serve(input logic [39:0] resp);
    s_wait = 0; s_to = 1'b0;
    while (cmd_start !== 1'b1 && s_wait < 3000) begin tick(); s_wait++; end
    if (cmd_start !== 1'b1) begin s_to = 1'b1; return; end
    s_idx = cmd_index; s_arg = cmd_arg; s_crc = cmd_crc; s_nr = cmd_nresp;
    tick(); s_single = (cmd_start === 1'b0);
    tick(); tick();
    cmd_done = 1'b1; cmd_resp = resp;
    tick();
    cmd_done = 1'b0; cmd_resp = '0;
  endtask

  task automatic no_more_cmds(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin tick(); if (cmd_start === 1'b1) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL %s: got extra cmd_start, want none", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    checks++;
    if ({busy, ready, error, cmd_start} !== 4'b0) begin
      errors++; $display("FAIL reset_status: got %b, want 0000", {busy, ready, error, cmd_start});
    end
    checks++;
    if ({err_code, sd_v2, ccs} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, want 00000", {err_code, sd_v2, ccs});
    end
    checks++;
    if ({cmd_index, cmd_arg, cmd_crc, cmd_nresp} !== 51'b0) begin
      errors++; $display("FAIL reset_frame: got idx=%0d arg=%h crc=%h nr=%0d, want 0",
                         cmd_index, cmd_arg, cmd_crc, cmd_nresp);
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_v2_card();
    int n, nbad;
    start_init(n);
    checks++;
    if (n !== 1024 || busy !== 1'b1) begin
      errors++; $display("FAIL powerup: got %0d cycles busy=%b, want 1024 busy=1", n, busy);
    end
    serve(40'h01_0000_0000);
    checks++;
    if (s_to || s_idx !== 6'd0 || s_arg !== 32'h0 || s_crc !== 7'h4A || s_nr !== 6'd0 || !s_single) begin
      errors++; $display("FAIL cmd0_frame: got to=%b idx=%0d arg=%h crc=%h nr=%0d single=%b, want 0/0/4a/0/1",
                         s_to, s_idx, s_arg, s_crc, s_nr, s_single);
    end
    serve({8'h01, 32'h0000_01AA});
    checks++;
    if (s_to || s_idx !== 6'd8 || s_arg !== 32'h1AA || s_crc !== 7'h43 || s_nr !== 6'd4) begin
      errors++; $display("FAIL cmd8_frame: got to=%b idx=%0d arg=%h crc=%h nr=%0d, want 8/1aa/43/4",
                         s_to, s_idx, s_arg, s_crc, s_nr);
    end
    nbad = 0;
    for (int i = 0; i < 4; i++) begin
      serve(40'h01_0000_0000);
      if (s_to || s_idx !== 6'd55 || s_crc !== 7'h7F || s_arg !== 32'h0) nbad++;
      if (i > 0 && s_wait !== 64) nbad++;
      serve(i < 3 ? 40'h01_0000_0000 : 40'h00_0000_0000);
      if (s_to || s_idx !== 6'd41 || s_arg !== 32'h4000_0000 || s_crc !== 7'h7F) nbad++;
    end
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL v2_acmd41_loop: got %0d bad frames/gaps, want 0", nbad); end
    if (HAS58) begin
      serve({8'h00, 32'hC0FF_8000});
      checks++;
      if (s_to || s_idx !== 6'd58 || s_nr !== 6'd4 || s_crc !== 7'h7F) begin
        errors++; $display("FAIL cmd58_frame: got to=%b idx=%0d nr=%0d, want 58/4", s_to, s_idx, s_nr);
      end
    end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || sd_v2 !== 1'b1 || ccs !== HAS58) begin
      errors++; $display("FAIL v2_status: got rdy=%b busy=%b err=%b v2=%b ccs=%b, want 1/0/0/1/%b",
                         ready, busy, error, sd_v2, ccs, HAS58);
    end
    no_more_cmds("v2_idle");
  endtask

  task automatic test_v1_card();
    int n, nbad;
    start_init(n);
    checks++;
    if (n !== 1024 || sd_v2 !== 1'b0 || ready !== 1'b0 || ccs !== 1'b0) begin
      errors++; $display("FAIL restart_clear: got n=%0d v2=%b rdy=%b ccs=%b, want 1024/0/0/0", n, sd_v2, ready, ccs);
    end
    nbad = 0;
    serve(40'h01_0000_0000); if (s_to || s_idx !== 6'd0) nbad++;
    serve(40'h05_0000_0000); if (s_to || s_idx !== 6'd8) nbad++;
    serve(40'h01_0000_0000); if (s_to || s_idx !== 6'd55) nbad++;
    serve(40'h00_0000_0000); if (s_to || s_idx !== 6'd41 || s_arg !== 32'h0) nbad++;
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL v1_sequence: got %0d bad frames, want 0", nbad); end
    checks++;
    if (ready !== 1'b1 || sd_v2 !== 1'b0 || ccs !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL v1_status: got rdy=%b v2=%b ccs=%b err=%b, want 1/0/0/0", ready, sd_v2, ccs, error);
    end
    no_more_cmds("v1_no_cmd58");
  endtask

  task automatic test_cmd0_retry();
    int n, nbad;
    start_init(n);
    nbad = 0;
    for (int i = 0; i < 8; i++) begin
      serve(40'hFF_0000_0000);
      if (s_to || s_idx !== 6'd0) nbad++;
      if (i > 0 && s_wait !== 64) nbad++;
    end
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL cmd0_retries: got %0d bad frames/gaps, want 0", nbad); end
    checks++;
    if (error !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL cmd0_error: got err=%b code=%0d busy=%b, want 1/1/0", error, err_code, busy);
    end
    no_more_cmds("cmd0_ninth");
  endtask

  task automatic test_cmd8_errors();
    int n;
    start_init(n);
    serve(40'h01_0000_0000);
    serve({8'h01, 32'h0000_00AA});
    checks++;
    if (s_to || error !== 1'b1 || err_code !== 3'd3 || sd_v2 !== 1'b0) begin
      errors++; $display("FAIL cmd8_echo: got err=%b code=%0d v2=%b, want 1/3/0", error, err_code, sd_v2);
    end
    no_more_cmds("cmd8_echo_stop");
    start_init(n);
    serve(40'h01_0000_0000);
    serve({8'h00, 32'h0000_01AA});
    checks++;
    if (s_to || error !== 1'b1 || err_code !== 3'd2) begin
      errors++; $display("FAIL cmd8_r1: got err=%b code=%0d, want 1/2", error, err_code);
    end
    start_init(n);
    serve(40'h01_0000_0000);
    serve({8'h01, 32'h0000_01AA});
    serve(40'hFF_0000_0000);
    checks++;
    if (s_to || s_idx !== 6'd55 || error !== 1'b1 || err_code !== 3'd4) begin
      errors++; $display("FAIL cmd55_r1: got idx=%0d err=%b code=%0d, want 55/1/4", s_idx, error, err_code);
    end
  endtask

  task automatic test_acmd41_timeout();
    int n, nbad, n41;
    start_init(n);
    serve(40'h01_0000_0000);
    serve({8'h01, 32'h0000_01AA});
    nbad = 0; n41 = 0;
    for (int i = 0; i < 255; i++) begin
      serve(40'h01_0000_0000);
      if (s_to || s_idx !== 6'd55) nbad++;
      serve(40'h01_0000_0000);
      if (s_to || s_idx !== 6'd41) nbad++; else n41++;
    end
    checks++;
    if (nbad !== 0 || n41 !== 255) begin
      errors++; $display("FAIL acmd41_count: got %0d acmd41 with %0d bad, want 255 with 0", n41, nbad);
    end
    checks++;
    if (error !== 1'b1 || err_code !== 3'd5 || busy !== 1'b0) begin
      errors++; $display("FAIL acmd41_timeout: got err=%b code=%0d busy=%b, want 1/5/0", error, err_code, busy);
    end
    no_more_cmds("acmd41_stop");
  endtask

  task automatic test_midreset();
    int n, w;
    start_init(n);
    serve(40'h01_0000_0000);
    w = 0;
    while (cmd_start !== 1'b1 && w < 100) begin tick(); w++; end
    tick();
    rst_n = 1'b0; tick();
    checks++;
    if ({busy, ready, error, cmd_start, err_code, sd_v2, ccs} !== 9'b0 ||
        {cmd_index, cmd_arg, cmd_crc, cmd_nresp} !== 51'b0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%b idx=%0d arg=%h v2=%b, want all 0",
                         busy, cmd_index, cmd_arg, sd_v2);
    end
    rst_n = 1'b1;
    no_more_cmds("midreset_quiet");
    start_init(n);
    serve(40'h01_0000_0000);
    checks++;
    if (n !== 1024 || s_to || s_idx !== 6'd0) begin
      errors++; $display("FAIL midreset_restart: got n=%0d idx=%0d, want 1024/0", n, s_idx);
    end
  endtask

  initial begin
    test_reset();
    test_v2_card();
    test_v1_card();
    test_cmd0_retry();
    test_cmd8_errors();
    test_acmd41_timeout();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
